// File: rtl/link_pkg.sv
// Shared definitions for the 4-bit serial link: default geometry, divider sizing
// and the receive-side state encoding.
package link_pkg;
   localparam int unsigned WIDTH_DEF    = 4;
   localparam int unsigned TICK_DIV_DEF = 100_000_000;
   localparam int unsigned CNT_W_DEF    = 27;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tick_gen.sv
// Slow shift-tick generator shared by both ends of the serial link.
// tick is a registered one-cycle pulse following the terminal divider count.
module tick_gen
   import link_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync,
   output logic tick
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      div_cnt_d = div_cnt_q;
      tick_d    = 1'b0;
      if (sync) begin
         div_cnt_d = '0;
      end else if (en) begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + CNT_W'(1);
         tick_d    = (div_cnt_q == DIV_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel receive stage: samples si on the shared shift tick, rebuilds
// LSB-first words and offers them on a valid/ready handshake with overrun tracking.
module sipo_frame_rx
   import link_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned TICK_DIV = TICK_DIV_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             si,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             overrun,
   output logic             busy
);

   localparam int unsigned      BCW      = cnt_bits(WIDTH);
   localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);

   rx_state_e        state_q, state_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;

   logic             tick;
   logic             sample;
   logic             word_done;
   logic [WIDTH-1:0] shreg_nxt;

   tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sync (sync),
      .tick (tick)
   );

   // Shift form stays legal for WIDTH=1, where the incoming bit is the whole word.
   assign shreg_nxt = (shreg_q >> 1) | (WIDTH'(si) << (WIDTH - 1));
   assign sample    = tick & en & ~sync;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      word_done  = 1'b0;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      if (sync) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         shreg_d   = '0;
         overrun_d = 1'b0;
      end else if (sample) begin
         shreg_d = shreg_nxt;
         if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
         end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            state_d   = SHIFT;
         end
      end

      // A word accepted in the same cycle frees the slot for the new one.
      if (word_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_nxt;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign overrun  = overrun_q;
   assign busy     = (bit_cnt_q != '0);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx with a 4-cycle shift tick.
module tb_sipo_frame_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       sync;
   logic       si;
   logic       rx_ready;
   logic [3:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic       busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned xfer_cnt = 0;
   int          edges_to_sample = 5;
   logic [3:0]  exp_q[$];

   sipo_frame_rx #(
      .WIDTH    (4),
      .TICK_DIV (4),
      .CNT_W    (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .si       (si),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] front();
      return (exp_q.size() != 0) ? {28'd0, exp_q[0]} : 'x;
   endfunction

   // Every accepted word must be the oldest one the bench expects.
   always @(negedge clk) begin
      if (rst && rx_valid && rx_ready) begin
         xfer_cnt++;
         chk("xfer_avail", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("xfer_data", rx_data, exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      edges_to_sample--;
   endtask

   task automatic sync_pulse();
      sync = 1'b1;
      @(posedge clk);
      #1;
      sync = 1'b0;
      edges_to_sample = 5;
   endtask

   task automatic send_bits(input logic [3:0] w, input int lo, input int hi, input bit ready_last);
      for (int i = lo; i <= hi; i++) begin
         si = w[i];
         if (ready_last && i == hi) begin
            while (edges_to_sample > 1) step();
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
         end else begin
            while (edges_to_sample > 0) step();
         end
         edges_to_sample = 4;
      end
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("consume_valid", rx_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; en = 1'b1; sync = 1'b0; si = 1'b0; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;

      // basic word, held until accepted
      sync_pulse();
      exp_q.push_back(4'b1101);
      send_bits(4'b1101, 0, 3, 0);
      chk("basic_valid", rx_valid, 1);
      chk("basic_data", rx_data, front());
      repeat (5) step();
      chk("basic_hold_valid", rx_valid, 1);
      chk("basic_hold_data", rx_data, front());
      consume();

      // reset mid-word with an unconsumed word pending
      sync_pulse();
      exp_q.push_back(4'hE);
      send_bits(4'hE, 0, 3, 0);
      send_bits(4'h7, 0, 1, 0);
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_valid", rx_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_data", rx_data, 0);
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_ovr", overrun, 0);
      chk("mid_rst_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      edges_to_sample = 5;
      chk("post_rst_busy", busy, 0);
      exp_q.push_back(4'h7);
      send_bits(4'h7, 0, 3, 0);
      chk("post_rst_valid", rx_valid, 1);
      chk("post_rst_data", rx_data, front());
      consume();

      // back-to-back with ready held high
      sync_pulse();
      rx_ready = 1'b1;
      exp_q.push_back(4'hA);
      send_bits(4'hA, 0, 3, 0);
      chk("b2b_a_valid", rx_valid, 1);
      chk("b2b_a_data", rx_data, front());
      step();
      chk("b2b_gap_valid", rx_valid, 0);
      exp_q.push_back(4'h5);
      send_bits(4'h5, 0, 3, 0);
      chk("b2b_5_valid", rx_valid, 1);
      chk("b2b_5_data", rx_data, front());
      step();
      chk("b2b_end_valid", rx_valid, 0);
      rx_ready = 1'b0;
      chk("b2b_ovr", overrun, 0);

      // overrun: second word dropped, sync clears the flag only
      sync_pulse();
      exp_q.push_back(4'h3);
      send_bits(4'h3, 0, 3, 0);
      chk("ovr_first_data", rx_data, front());
      send_bits(4'hC, 0, 3, 0);
      chk("ovr_kept_data", rx_data, front());
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", rx_valid, 1);
      sync_pulse();
      chk("ovr_sync_flag", overrun, 0);
      chk("ovr_sync_valid", rx_valid, 1);
      chk("ovr_sync_data", rx_data, front());

      // accept coincident with completion of the next word
      exp_q.push_back(4'h9);
      send_bits(4'h9, 0, 3, 1);
      chk("coin_valid", rx_valid, 1);
      chk("coin_data", rx_data, front());
      chk("coin_ovr", overrun, 0);
      consume();

      // enable freeze mid-word
      sync_pulse();
      exp_q.push_back(4'h6);
      send_bits(4'h6, 0, 1, 0);
      chk("en_busy_pre", busy, 1);
      en = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      en = 1'b1;
      chk("en_busy_held", busy, 1);
      chk("en_valid_held", rx_valid, 0);
      send_bits(4'h6, 2, 3, 0);
      chk("en_valid", rx_valid, 1);
      chk("en_data", rx_data, front());
      consume();

      // sync coincident with a tick: no sample, phase restarts
      while (edges_to_sample > 1) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      edges_to_sample = 5;
      chk("sync_tick_busy", busy, 0);
      exp_q.push_back(4'hB);
      si = 1'b1;
      repeat (4) step();
      chk("sync_phase_early", busy, 0);
      step();
      chk("sync_phase_first", busy, 1);
      edges_to_sample = 4;
      send_bits(4'hB, 1, 3, 0);
      chk("sync_word_valid", rx_valid, 1);
      chk("sync_word_data", rx_data, front());
      consume();

      chk("final_xfers", xfer_cnt, 8);
      chk("final_queue", exp_q.size(), 0);
      chk("final_ovr", overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
